// File: rtl/reflet_prefetch_queue.sv
// reflet_prefetch_queue: byte-instruction prefetcher between the 16-bit dual-byte
// program ROM and the reflet decoder. Keeps a small byte FIFO topped up with ROM
// reads and hands out one opcode per handshake, tagged with its PC. A flush drops
// queued and in-flight bytes and restarts fetch at the new address.
//
// Optional feature macro: REFLET_PREFETCH_BYPASS_EN
//   When defined, a ROM response arriving into an empty queue is presented to the
//   consumer combinationally in the response cycle (first-instruction latency t+1).
//   When undefined, rom_data never reaches instr/instr_valid combinationally.
module reflet_prefetch_queue #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [15:0]           rom_data,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  output logic [7:0]            instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 2;

  // Byte storage and queue bookkeeping
  logic [7:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_nxt_c;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [7:0]            last_instr_q;

  // Per-cycle control
  logic                  fifo_empty_c;
  logic                  bypass_c;
  logic                  transfer_c;
  logic                  pop_c;
  logic                  push_lo_c;
  logic                  push_hi_c;
  logic                  issue_c;
  logic [SUM_W-1:0]      demand_c;

  // Consumer-facing view of the queue head (and of the bypassed ROM byte if enabled)
  always_comb begin
    fifo_empty_c = (count_q == '0);
`ifdef REFLET_PREFETCH_BYPASS_EN
    bypass_c     = fifo_empty_c && pending_q && !flush;
    instr_valid  = !fifo_empty_c || bypass_c;
    if (!fifo_empty_c)
      instr = mem_q[rd_ptr_q];
    else if (bypass_c)
      instr = rom_data[7:0];
    else
      instr = last_instr_q;
`else
    bypass_c     = 1'b0;
    instr_valid  = !fifo_empty_c;
    instr        = fifo_empty_c ? last_instr_q : mem_q[rd_ptr_q];
`endif
    instr_pc     = head_pc_q;
    rom_addr     = fetch_addr_q;
    rom_enable   = pending_q;
  end

  // Handshake, push/pop and issue decisions for this cycle
  always_comb begin
    transfer_c   = instr_valid && instr_ready && !flush;
    pop_c        = transfer_c && !fifo_empty_c;
    // A bypassed low byte that is consumed right away is not stored
    push_hi_c    = pending_q && !flush;
    push_lo_c    = push_hi_c && !(bypass_c && instr_ready);
    demand_c     = SUM_W'(count_q) + SUM_W'({pending_q, 1'b0}) + SUM_W'(2);
    issue_c      = !flush && (demand_c <= SUM_W'(DEPTH));
    wr_ptr_nxt_c = wr_ptr_q + PTR_W'(1);
  end

  // Next-state computation; flush overrides everything
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pending_d    = pending_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      pending_d    = 1'b0;
      fetch_addr_d = flush_addr;
      head_pc_d    = flush_addr;
    end else begin
      pending_d = issue_c;
      if (issue_c)
        fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(2);
      if (transfer_c)
        head_pc_d = head_pc_q + ADDR_WIDTH'(1);
      if (pop_c)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_lo_c) + PTR_W'(push_hi_c);
      count_d  = count_q + CNT_W'(push_lo_c) + CNT_W'(push_hi_c) - CNT_W'(pop_c);
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      fetch_addr_q <= '0;
      head_pc_q    <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  // Byte storage: low byte first, then high byte, or high byte alone after a bypass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem_q[i] <= '0;
    end else if (push_lo_c) begin
      mem_q[wr_ptr_q]     <= rom_data[7:0];
      mem_q[wr_ptr_nxt_c] <= rom_data[15:8];
    end else if (push_hi_c) begin
      mem_q[wr_ptr_q]     <= rom_data[15:8];
    end
  end

  // Remember the last displayed opcode so instr holds steady while the queue is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_instr_q <= '0;
    else
      last_instr_q <= instr;
  end

endmodule

// File: tb/tb_reflet_prefetch_queue.sv
// Bench for reflet_prefetch_queue: directed scenarios followed by random traffic.
// The reference model is the expected program stream: starting from the last
// redirect target, the consumer must see rom[pc], rom[pc+1], ... in order.
`timescale 1ns/1ps
module tb_reflet_prefetch_queue;

  localparam int unsigned AW       = 7;
  localparam int unsigned ROM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rom_addr;
  logic          rom_enable;
  logic [15:0]   rom_data;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [7:0]    instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  reflet_prefetch_queue #(.ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_enable  (rom_enable),
    .rom_data    (rom_data),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Dual-byte ROM: registers the address every edge, output gated by rom_enable
  logic [7:0]    rom [ROM_SIZE];
  logic [15:0]   rom_q;
  logic [AW-1:0] rom_addr_p1;
  assign rom_addr_p1 = rom_addr + AW'(1);
  always @(posedge clk) rom_q <= {rom[rom_addr_p1], rom[rom_addr]};
  assign rom_data = rom_enable ? rom_q : 16'hDEAD;

  int            total = 0;
  int            bad = 0;
  int            streak = 0;
  int            transfers = 0;
  logic [AW-1:0] exp_pc = '0;
  logic [7:0]    last_seen = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the cycle at negedge, advance the model, return after the edge
  task automatic step();
    @(negedge clk);
    if (reset) begin
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_romen", 32'(rom_enable), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      exp_pc    = '0;
      last_seen = '0;
      streak    = 0;
    end else begin
      if (instr_valid) begin
        chk("head_pc", 32'(instr_pc), 32'(exp_pc));
        chk("head_byte", 32'(instr), 32'(rom[exp_pc]));
        streak = 0;
      end else begin
        chk("hold_instr", 32'(instr), 32'(last_seen));
        streak++;
        chk("starve", 32'(streak <= 3), 32'd1);
      end
      last_seen = instr;
      if (flush) begin
        exp_pc = flush_addr;
        streak = 0;
      end else if (instr_valid && instr_ready) begin
        exp_pc++;
        transfers++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_romen(input string tag);
    int n = 0;
    while (!rom_enable && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(rom_enable), 32'd1);
  endtask

  task automatic restart(input logic rdy);
    reset       = 1'b1;
    flush       = 1'b0;
    instr_ready = rdy;
    step();
    reset = 1'b0;
    step();
  endtask

  logic [7:0]    seq [4];
  logic [7:0]    wrap_seq [4];
  logic [AW-1:0] p;

  initial begin
    for (int i = 0; i < int'(ROM_SIZE); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h41; rom[1] = 8'h53; rom[2] = 8'h52; rom[3] = 8'h4D;
    rom[7'h4F] = 8'h0B; rom[7'h50] = 8'h16;
    seq[0] = 8'h41; seq[1] = 8'h53; seq[2] = 8'h52; seq[3] = 8'h4D;

    reset = 1'b1; flush = 1'b0; flush_addr = '0; instr_ready = 1'b1;
    #1;
    step();
    step();

    // Test 1: release reset, stream from address 0
    reset = 1'b0;
    step();
    chk("t1_romen", 32'(rom_enable), 32'd1);
`ifdef REFLET_PREFETCH_BYPASS_EN
    chk("t1_lat_valid", 32'(instr_valid), 32'd1);
`else
    chk("t1_lat_valid", 32'(instr_valid), 32'd0);
    step();
`endif
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_byte", 32'(instr), 32'(seq[i]));
      chk("t1_pc", 32'(instr_pc), 32'(i));
      step();
    end

    // Test 2: consumer stalled, queue fills and fetch stops
    restart(1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("t2_romen", 32'(rom_enable), 32'd0);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_byte", 32'(instr), 32'h41);
    chk("t2_pc", 32'(instr_pc), 32'd0);
    chk("t2_addr", 32'(rom_addr), 32'd4);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_unbroken", 32'(instr_valid), 32'd1);
      step();
    end

    // Test 3: flush while a response is in flight
    wait_romen("t3_inflight");
    flush = 1'b1; flush_addr = 7'h4F;
    step();
    flush = 1'b0;
    chk("t3_f1_valid", 32'(instr_valid), 32'd0);
    chk("t3_f1_romen", 32'(rom_enable), 32'd0);
    chk("t3_f1_addr", 32'(rom_addr), 32'h4F);
    step();
    chk("t3_f2_romen", 32'(rom_enable), 32'd1);
`ifndef REFLET_PREFETCH_BYPASS_EN
    chk("t3_f2_valid", 32'(instr_valid), 32'd0);
    step();
`endif
    chk("t3_first_byte", 32'(instr), 32'h0B);
    chk("t3_first_pc", 32'(instr_pc), 32'h4F);
    step();
    chk("t3_second_byte", 32'(instr), 32'h16);
    chk("t3_second_pc", 32'(instr_pc), 32'h50);

    // Test 4: redirect near the top of the address space, stream wraps to 0
    wrap_seq[0] = rom[7'h7E]; wrap_seq[1] = rom[7'h7F];
    wrap_seq[2] = 8'h41;      wrap_seq[3] = 8'h53;
    flush = 1'b1; flush_addr = 7'h7E;
    step();
    flush = 1'b0;
    wait_valid("t4_start");
    p = 7'h7E;
    for (int i = 0; i < 4; i++) begin
      chk("t4_pc", 32'(instr_pc), 32'(p));
      chk("t4_byte", 32'(instr), 32'(wrap_seq[i]));
      p++;
      step();
    end

    // Test 5: reset with a response pending
    wait_romen("t5_pending");
    reset = 1'b1;
    #1;
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_romen", 32'(rom_enable), 32'd0);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    step();
    reset = 1'b0;
    wait_valid("t5_restart");
    chk("t5_byte", 32'(instr), 32'h41);
    chk("t5_pc", 32'(instr_pc), 32'd0);

`ifdef REFLET_PREFETCH_BYPASS_EN
    // Test 6: flush in the bypass cycle voids the transfer
    restart(1'b1);
    chk("t6_bypass_valid", 32'(instr_valid), 32'd1);
    chk("t6_bypass_byte", 32'(instr), 32'h41);
    flush = 1'b1; flush_addr = 7'h10;
    step();
    flush = 1'b0;
    wait_valid("t6_after_flush");
    chk("t6_pc", 32'(instr_pc), 32'h10);
    chk("t6_byte", 32'(instr), 32'(rom[7'h10]));
`endif

    // Random traffic: ready, flushes and occasional resets
    transfers = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 39) == 0);
      flush_addr  = AW'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0;
    step();
    chk("rand_progress", 32'(transfers > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
